// File: rtl/regfile_pkg.sv
// regfile_pkg: shared helpers and constants for the multi-port register file
package regfile_pkg;
  localparam int ZERO_REG = '0;
  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port with write bypass and readiness
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  localparam int AW = addr_width(NREGS)
) (
  input  logic [AW-1:0]       addr_i,
  input  logic [NWR-1:0]      wr_en_i,
  input  logic [NWR*AW-1:0]   wr_addr_i,
  input  logic [NWR*XLEN-1:0] wr_data_i,
  input  logic [XLEN-1:0]     regs_i [NREGS],
  input  logic [NREGS-1:0]    pending_i,
  output logic [XLEN-1:0]     data_o,
  output logic                ready_o
);
  logic            hit;
  logic [XLEN-1:0] byp;
  // highest-index matching write wins the bypass; x0 always reads zero and ready
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int w = 0; w < NWR; w++)
      if (BYPASS != 0 && wr_en_i[w] && wr_addr_i[w*AW +: AW] == addr_i) begin
        hit = 1'b1;
        byp = wr_data_i[w*XLEN +: XLEN];
      end
    data_o = (addr_i == AW'(ZERO_REG)) ? '0 : hit ? byp : regs_i[addr_i];
    ready_o = addr_i == AW'(ZERO_REG) || hit || !pending_i[addr_i];
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass and pending-bit scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  localparam int AW = addr_width(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_ready,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [NREGS-1:0]    pending,
  output logic                wr_conflict
);
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pending_q, pending_d, wen;
  logic             conflict_q, conflict_d;
  logic [NWR-1:0]   byp_en;

  // bypass is suppressed while in reset so reads return zero
  assign byp_en = rst_n ? wr_en : '0;

  // write arbitration (highest port wins), scoreboard next state, conflict detect
  always_comb begin
    regs_d = regs_q;
    wen = '0;
    pending_d = '0;
    conflict_d = 1'b0;
    for (int r = 1; r < NREGS; r++)
      for (int w = 0; w < NWR; w++)
        if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(r)) begin
          wen[r] = 1'b1;
          regs_d[r] = wr_data[w*XLEN +: XLEN];
        end
    for (int r = 1; r < NREGS; r++)
      pending_d[r] = (rsv_en && rsv_addr == AW'(r)) || (pending_q[r] && !wen[r]);
    for (int i = 0; i < NWR; i++)
      for (int j = i + 1; j < NWR; j++)
        conflict_d |= wr_en[i] && wr_en[j] && wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]
                      && wr_addr[i*AW +: AW] != AW'(ZERO_REG);
  end

  // state update; reset discards any in-flight write or reservation
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs_q <= '{default: '0};
      pending_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      pending_q <= pending_d;
      conflict_q <= conflict_d;
    end

  assign pending = pending_q;
  assign wr_conflict = conflict_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rd_port #(
      .XLEN(XLEN), .NREGS(NREGS), .NWR(NWR), .BYPASS(BYPASS)
    ) u_rd (
      .addr_i(rd_addr[k*AW +: AW]),
      .wr_en_i(byp_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .regs_i(regs_q),
      .pending_i(pending_q),
      .data_o(rd_data[k*XLEN +: XLEN]),
      .ready_o(rd_ready[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp with and without bypass against a behavioural model
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [63:0] rd_data1, rd_data0;
  logic [1:0]  rdy1, rdy0;
  logic [31:0] pend1, pend0;
  logic        conf1, conf0;
  int total = 0, bad = 0;
  logic [31:0] mem [32];
  logic [31:0] pend_m;
  logic        conf_m;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_ready(rdy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .pending(pend1), .wr_conflict(conf1));

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_ready(rdy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .pending(pend0), .wr_conflict(conf0));

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic [32:0] exp_rd(input bit b, input logic [4:0] a);
    if (a == 5'd0) return {1'b1, 32'h0};
    for (int w = 1; w >= 0; w--)
      if (b && rst_n && wr_en[w] && wr_addr[w*5 +: 5] == a) return {1'b1, wr_data[w*32 +: 32]};
    return {!pend_m[a], mem[a]};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int cnt [32];
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      pend_m = '0;
      conf_m = 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt[i] = 0;
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_addr[w*5 +: 5] != 5'd0) begin
          mem[wr_addr[w*5 +: 5]] = wr_data[w*32 +: 32];
          pend_m[wr_addr[w*5 +: 5]] = 1'b0;
          cnt[wr_addr[w*5 +: 5]]++;
        end
      if (rsv_en && rsv_addr != 5'd0) pend_m[rsv_addr] = 1'b1;
      conf_m = 1'b0;
      for (int i = 1; i < 32; i++) if (cnt[i] > 1) conf_m = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("rd_byp", {rdy1[k], rd_data1[k*32 +: 32]}, 64'(exp_rd(1'b1, rd_addr[k*5 +: 5])));
      chk("rd_nobyp", {rdy0[k], rd_data0[k*32 +: 32]}, 64'(exp_rd(1'b0, rd_addr[k*5 +: 5])));
    end
    chk("pend_byp", 64'(pend1), 64'(pend_m));
    chk("pend_nobyp", 64'(pend0), 64'(pend_m));
    chk("conf_byp", 64'(conf1), 64'(conf_m));
    chk("conf_nobyp", 64'(conf0), 64'(conf_m));
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_addr[p*5 +: 5] = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic idle;
    wr_en = '0;
    rsv_en = 1'b0;
  endtask

  initial begin
    rd_addr = {5'd5, 5'd5};
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    rsv_en = 1'b0;
    rsv_addr = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_rd", rd_data1, 64'h0);
    chk("rst_rdy", 64'(rdy1), 64'h3);
    chk("rst_pend", 64'(pend1), 64'h0);
    #8 rst_n = 1'b1;
    cyc;
    wr(0, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("x5_byp", 64'(rd_data1[31:0]), 64'hDEAD_BEEF);
    chk("x5_nobyp_old", 64'(rd_data0[31:0]), 64'h0);
    cyc;
    idle;
    chk("x5_next", 64'(rd_data0[31:0]), 64'hDEAD_BEEF);
    wr(0, 5'd0, 32'h1234);
    wr(1, 5'd0, 32'h1234);
    rsv_en = 1'b1;
    rsv_addr = 5'd0;
    rd_addr = {5'd0, 5'd5};
    #1;
    chk("x0_byp", 64'(rd_data1[63:32]), 64'h0);
    cyc;
    idle;
    chk("x0_pend", 64'(pend1[0]), 64'h0);
    chk("x0_conf", 64'(conf1), 64'h0);
    chk("x0_rd", 64'(rd_data0[63:32]), 64'h0);
    wr(0, 5'd7, 32'hAAAA);
    wr(1, 5'd7, 32'hBBBB);
    rd_addr = {5'd0, 5'd7};
    #1;
    chk("coll_byp", 64'(rd_data1[31:0]), 64'hBBBB);
    cyc;
    idle;
    chk("coll_x7", 64'(rd_data0[31:0]), 64'hBBBB);
    chk("coll_conf_set", 64'(conf1), 64'h1);
    cyc;
    chk("coll_conf_clr", 64'(conf1), 64'h0);
    wr(0, 5'd9, 32'h11);
    cyc;
    idle;
    wr(1, 5'd9, 32'h55);
    rd_addr = {5'd7, 5'd9};
    #1;
    chk("byp_new", 64'(rd_data1[31:0]), 64'h55);
    chk("nobyp_old", 64'(rd_data0[31:0]), 64'h11);
    cyc;
    idle;
    chk("nobyp_new", 64'(rd_data0[31:0]), 64'h55);
    rsv_en = 1'b1;
    rsv_addr = 5'd3;
    rd_addr = {5'd3, 5'd9};
    cyc;
    idle;
    chk("pend3_set", 64'(pend1[3]), 64'h1);
    chk("rdy3_busy", 64'(rdy1[1]), 64'h0);
    wr(0, 5'd3, 32'h77);
    #1;
    chk("rdy3_byp", 64'(rdy1[1]), 64'h1);
    chk("rdy3_nobyp", 64'(rdy0[1]), 64'h0);
    cyc;
    idle;
    chk("pend3_clr", 64'(pend1[3]), 64'h0);
    rsv_en = 1'b1;
    rsv_addr = 5'd3;
    wr(1, 5'd3, 32'h88);
    cyc;
    idle;
    chk("pend3_keep", 64'(pend1[3]), 64'h1);
    chk("x3_data", 64'(rd_data0[63:32]), 64'h88);
    wr(0, 5'd7, 32'h99);
    rd_addr = {5'd3, 5'd7};
    #2 rst_n = 1'b0;
    #1;
    chk("mr_pend", 64'(pend1), 64'h0);
    chk("mr_pend_nobyp", 64'(pend0), 64'h0);
    chk("mr_rd", rd_data1, 64'h0);
    chk("mr_rdy", 64'(rdy1), 64'h3);
    chk("mr_x7", 64'(rd_data0[31:0]), 64'h0);
    idle;
    #3 rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc;
      idle;
      wr(i % 2, 5'(i), 32'(i) * 32'h111);
      rsv_en = 1'b1;
      rsv_addr = 5'(i + 8);
      rd_addr = {5'(i + 7), 5'(i)};
    end
    cyc;
    idle;
    cyc;
    cyc;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
